// File: rtl/vga_timing_pkg.sv
// Default video mode (640x480@60) and line/frame total derivation shared by the
// timing generator and the pixel-generation blocks.
package vga_timing_pkg;

  localparam int unsigned DefHDisplay = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVDisplay = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;
  localparam int unsigned DefClkDiv   = 2;
  localparam int unsigned DefCoordW   = 10;

  function automatic int unsigned mode_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  localparam int unsigned DefHTotal = mode_total(DefHDisplay, DefHFront, DefHSync, DefHBack);
  localparam int unsigned DefVTotal = mode_total(DefVDisplay, DefVFront, DefVSync, DefVBack);

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with enable, a configurable reset-load value and a wrap strobe.
// The next-state value is exported so callers can register derived outputs in step.
module vga_wrap_counter #(
  parameter int unsigned Width    = 10,
  parameter int unsigned Modulo   = 2,
  parameter int unsigned ResetVal = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_next_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Modulo - 1);
  localparam logic [Width-1:0] RstVal = Width'(ResetVal);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             at_max;

  always_comb begin
    at_max = (cnt_q == MaxVal);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + Width'(1);
    end
  end

  assign wrap_o     = en_i & at_max;
  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RstVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, h/v counters and a single
// bank of output registers so sync, coordinates, enable and strobes stay skew-free.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DefHDisplay,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_DISPLAY = DefVDisplay,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0,
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned COORD_W   = DefCoordW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               video_on_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               pixel_tick_o,
  output logic               line_start_o,
  output logic               frame_start_o
);

  localparam int unsigned HTotal = mode_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = mode_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [COORD_W-1:0] HDisp    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] VDisp    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HsStart  = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HsEnd    = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VsStart  = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VsEnd    = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Totals must fit the coordinate width; the shift form also covers COORD_W >= 32.
  if (((HTotal - 1) >> COORD_W) != 0 || ((VTotal - 1) >> COORD_W) != 0) begin : g_bad_coord_w
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("vga_timing_gen: sync widths must be non-zero");
  end

  logic [DivW-1:0]    div_cnt, div_cnt_next;
  logic [COORD_W-1:0] h_cnt, h_next, v_cnt, v_next;
  logic               tick, h_wrap, v_wrap;

  vga_wrap_counter #(
    .Width   (DivW),
    .Modulo  (CLK_DIV),
    .ResetVal(0)
  ) u_div_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (1'b1),
    .cnt_o     (div_cnt),
    .cnt_next_o(div_cnt_next),
    .wrap_o    (tick)
  );

  // Reset-load at the last position so the first tick lands on (0,0).
  vga_wrap_counter #(
    .Width   (COORD_W),
    .Modulo  (HTotal),
    .ResetVal(HTotal - 1)
  ) u_h_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (tick),
    .cnt_o     (h_cnt),
    .cnt_next_o(h_next),
    .wrap_o    (h_wrap)
  );

  vga_wrap_counter #(
    .Width   (COORD_W),
    .Modulo  (VTotal),
    .ResetVal(VTotal - 1)
  ) u_v_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (h_wrap),
    .cnt_o     (v_cnt),
    .cnt_next_o(v_next),
    .wrap_o    (v_wrap)
  );

  logic unused_cnt;
  assign unused_cnt = ^{div_cnt, div_cnt_next, h_cnt, v_cnt};

  logic               hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               pixel_tick_q, pixel_tick_d, line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  // Decode from next-state counters so every output moves on the tick edge together.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_tick_d  = tick;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    if (tick) begin
      x_d        = h_next;
      y_d        = v_next;
      hsync_d    = ((h_next >= HsStart) && (h_next <= HsEnd)) ? H_POL : ~H_POL;
      vsync_d    = ((v_next >= VsStart) && (v_next <= VsEnd)) ? V_POL : ~V_POL;
      video_on_d = (h_next < HDisp) && (v_next < VDisp);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign pixel_tick_o  = pixel_tick_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode, a tiny CLK_DIV=1 positive-polarity mode and a
// small CLK_DIV=3 mode for whole-frame checks, all against a closed-form raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       ls;
    logic       fs;
  } vid_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_von, d_pt, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_von, s_pt, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       m_hs, m_vs, m_von, m_pt, m_ls, m_fs;
  logic [9:0] m_x, m_y;

  vga_timing_gen u_dut_def (
    .clk_i(clk), .rst_ni(rst_n), .hsync_o(d_hs), .vsync_o(d_vs), .video_on_o(d_von),
    .x_o(d_x), .y_o(d_y), .pixel_tick_o(d_pt), .line_start_o(d_ls), .frame_start_o(d_fs)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .COORD_W(10)
  ) u_dut_small (
    .clk_i(clk), .rst_ni(rst_n), .hsync_o(s_hs), .vsync_o(s_vs), .video_on_o(s_von),
    .x_o(s_x), .y_o(s_y), .pixel_tick_o(s_pt), .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  vga_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .COORD_W(10)
  ) u_dut_mid (
    .clk_i(clk), .rst_ni(rst_n), .hsync_o(m_hs), .vsync_o(m_vs), .video_on_o(m_von),
    .x_o(m_x), .y_o(m_y), .pixel_tick_o(m_pt), .line_start_o(m_ls), .frame_start_o(m_fs)
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected outputs after k rising edges since reset release, derived from tick count.
  function automatic vid_t model(input int k, input int hd, input int hf, input int hsw,
                                 input int hb, input int vd, input int vf, input int vsw,
                                 input int vb, input bit hp, input bit vp, input int div);
    vid_t o;
    int   ht, vt, t, q, x, y;
    bit   tk;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    t  = k / div;
    if (t == 0) begin
      o = '{hs: ~hp, vs: ~vp, von: 1'b0, x: 10'd0, y: 10'd0, pt: 1'b0, ls: 1'b0, fs: 1'b0};
      return o;
    end
    q     = t - 1;
    x     = q % ht;
    y     = (q / ht) % vt;
    tk    = (k % div) == 0;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = (x >= hd + hf && x < hd + hf + hsw) ? hp : ~hp;
    o.vs  = (y >= vd + vf && y < vd + vf + vsw) ? vp : ~vp;
    o.von = (x < hd) && (y < vd);
    o.pt  = tk;
    o.ls  = tk && (x == 0);
    o.fs  = tk && (x == 0) && (y == 0);
    return o;
  endfunction

  int   k_edges = 0;
  vid_t q_def[$];
  vid_t q_small[$];
  vid_t q_mid[$];

  always @(posedge clk) begin
    if (!rst_n) k_edges = 0;
    else        k_edges++;
    q_def.push_back(model(k_edges, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2));
    q_small.push_back(model(k_edges, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 1));
    q_mid.push_back(model(k_edges, 16, 2, 4, 2, 10, 2, 2, 3, 1'b0, 1'b0, 3));
  end

  always @(negedge clk) begin
    vid_t e;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      check_eq("sb_def", {d_hs, d_vs, d_von, d_x, d_y, d_pt, d_ls, d_fs}, e);
    end
    if (q_small.size() > 0) begin
      e = q_small.pop_front();
      check_eq("sb_small", {s_hs, s_vs, s_von, s_x, s_y, s_pt, s_ls, s_fs}, e);
    end
    if (q_mid.size() > 0) begin
      e = q_mid.pop_front();
      check_eq("sb_mid", {m_hs, m_vs, m_von, m_x, m_y, m_pt, m_ls, m_fs}, e);
    end
  end

  initial begin
    int cyc, last_tick, per_min, per_max, hlo_min, hlo_max, n_fall;
    int m_ticks, m_frames, m_px, m_py, m_vlo_min, m_vlo_max;
    int s_zero, s_hhi_min, s_hhi_max, s_vhi_min, s_vhi_max, n;
    bit prev_von, found;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_x", d_x, 0);
    check_eq("rst_y", d_y, 0);
    check_eq("rst_von", d_von, 0);
    check_eq("rst_hs", d_hs, 1);
    check_eq("rst_vs", d_vs, 1);
    check_eq("rst_strobes", {d_pt, d_ls, d_fs}, 0);
    check_eq("rst_small_sync", {s_hs, s_vs}, 0);

    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("first_strobes", {d_pt, d_ls, d_fs}, 3'b111);
    check_eq("first_xy", {d_x, d_y}, 0);
    check_eq("first_von", d_von, 1);

    cyc = 0; last_tick = -1; per_min = 1000; per_max = 0;
    hlo_min = 1000; hlo_max = -1; n_fall = 0; prev_von = d_von;
    m_ticks = 0; m_frames = 0; m_px = 0; m_py = 0; m_vlo_min = 1000; m_vlo_max = -1;
    s_zero = 0; s_hhi_min = 1000; s_hhi_max = -1; s_vhi_min = 1000; s_vhi_max = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cyc++;
      if (d_pt) begin
        if (last_tick >= 0) begin
          if (cyc - last_tick < per_min) per_min = cyc - last_tick;
          if (cyc - last_tick > per_max) per_max = cyc - last_tick;
        end
        last_tick = cyc;
      end
      if (!d_hs) begin
        if (int'(d_x) < hlo_min) hlo_min = int'(d_x);
        if (int'(d_x) > hlo_max) hlo_max = int'(d_x);
      end
      if (prev_von && !d_von) begin
        n_fall++;
        check_eq("von_fall_x", d_x, 640);
      end
      if (!prev_von && d_von) check_eq("von_rise_x", d_x, 0);
      prev_von = d_von;

      if (m_pt) begin
        m_ticks++;
        if (m_fs) begin
          if (m_frames > 0) begin
            check_eq("mid_frame_ticks", m_ticks, 408);
            check_eq("mid_wrap_from", {10'(m_px), 10'(m_py)}, {10'd23, 10'd16});
          end
          m_frames++;
          m_ticks = 0;
        end
        m_px = int'(m_x);
        m_py = int'(m_y);
      end
      if (!m_vs) begin
        if (int'(m_y) < m_vlo_min) m_vlo_min = int'(m_y);
        if (int'(m_y) > m_vlo_max) m_vlo_max = int'(m_y);
      end

      if (!s_pt) s_zero++;
      if (s_hs) begin
        if (int'(s_x) < s_hhi_min) s_hhi_min = int'(s_x);
        if (int'(s_x) > s_hhi_max) s_hhi_max = int'(s_x);
      end
      if (s_vs) begin
        if (int'(s_y) < s_vhi_min) s_vhi_min = int'(s_y);
        if (int'(s_y) > s_vhi_max) s_vhi_max = int'(s_y);
      end
    end

    check_eq("tick_period_min", per_min, 2);
    check_eq("tick_period_max", per_max, 2);
    check_eq("hsync_lo_first", hlo_min, 656);
    check_eq("hsync_lo_last", hlo_max, 751);
    check_eq("von_falls_seen", n_fall >= 3, 1);
    check_eq("mid_frames_seen", m_frames >= 3, 1);
    check_eq("mid_vsync_lo_first", m_vlo_min, 12);
    check_eq("mid_vsync_lo_last", m_vlo_max, 13);
    check_eq("small_tick_gaps", s_zero, 0);
    check_eq("small_hsync_hi_first", s_hhi_min, 10);
    check_eq("small_hsync_hi_last", s_hhi_max, 12);
    check_eq("small_vsync_hi_first", s_vhi_min, 5);
    check_eq("small_vsync_hi_last", s_vhi_max, 6);

    // Asynchronous reset in the middle of a line, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (d_x == 10'd300) found = 1'b1;
    end
    check_eq("find_x300", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_xy", {d_x, d_y}, 0);
    check_eq("arst_von", d_von, 0);
    check_eq("arst_sync", {d_hs, d_vs}, 2'b11);
    check_eq("arst_strobes", {d_pt, d_ls, d_fs}, 0);
    check_eq("arst_small_sync", {s_hs, s_vs}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 10 && !found) begin
      @(posedge clk);
      #1;
      n++;
      if (d_fs) found = 1'b1;
    end
    check_eq("rerelease_fs_latency", found ? n : -1, 2);

    repeat (50) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
